// File: rtl/dibu_ctrl_alu_mem_pkg.sv
// Shared constants for the dibu control sequencer, ALU and RAM bundle:
// control-word bit map, opcodes, ALU op codes, flag positions and FSM states.
package dibu_ctrl_alu_mem_pkg;

    localparam int SIGNALS_SIZE = 13;

    localparam int SIG_IR_W_EN    = 0;
    localparam int SIG_PC_INC     = 1;
    localparam int SIG_MAR_W_EN   = 2;
    localparam int SIG_REG_RW     = 3;
    localparam int SIG_ALU_OUT_EN = 4;
    localparam int SIG_FLAGS_EN   = 5;
    localparam int SIG_IMM_EN     = 6;
    localparam int SIG_DAR_W_EN   = 7;
    localparam int SIG_MDR_W_EN   = 8;
    localparam int SIG_DMEM_W_EN  = 9;
    localparam int SIG_MDR_OUT_EN = 10;
    localparam int SIG_REG_TO_MDR = 11;
    localparam int SIG_FLAGS_W_EN = 12;

    localparam logic [4:0] OP_LD_DIRECT   = 5'b10000;
    localparam logic [4:0] OP_ST_DIRECT   = 5'b10001;
    localparam logic [4:0] OP_LD_INDIRECT = 5'b10010;
    localparam logic [4:0] OP_ST_INDIRECT = 5'b10011;
    localparam logic [4:0] OP_LDI         = 5'b01000;
    localparam logic [4:0] OP_RDF         = 5'b01001;
    localparam logic [4:0] OP_HALT        = 5'b11111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_NOT = 3'b101,
        ALU_SHL = 3'b110,
        ALU_SHR = 3'b111
    } alu_op_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [3:0] {
        ST_F0, ST_F1, ST_D, ST_ALU, ST_LDI, ST_RDF,
        ST_LD0, ST_LD1, ST_LD2, ST_ST0, ST_ST1, ST_HALT
    } state_t;

    function automatic logic [SIGNALS_SIZE-1:0] state_signals(input state_t st);
        logic [SIGNALS_SIZE-1:0] s;
        s = '0;
        case (st)
            ST_F0:  begin s[SIG_MAR_W_EN] = 1'b1; s[SIG_PC_INC] = 1'b1; end
            ST_F1:  s[SIG_IR_W_EN] = 1'b1;
            ST_ALU: begin
                s[SIG_ALU_OUT_EN] = 1'b1;
                s[SIG_REG_RW]     = 1'b1;
                s[SIG_FLAGS_W_EN] = 1'b1;
            end
            ST_LDI: begin s[SIG_IMM_EN] = 1'b1; s[SIG_REG_RW] = 1'b1; end
            ST_RDF: begin s[SIG_FLAGS_EN] = 1'b1; s[SIG_REG_RW] = 1'b1; end
            ST_LD0: s[SIG_DAR_W_EN] = 1'b1;
            ST_LD1: s[SIG_MDR_W_EN] = 1'b1;
            ST_LD2: begin s[SIG_MDR_OUT_EN] = 1'b1; s[SIG_REG_RW] = 1'b1; end
            ST_ST0: begin
                s[SIG_DAR_W_EN]   = 1'b1;
                s[SIG_MDR_W_EN]   = 1'b1;
                s[SIG_REG_TO_MDR] = 1'b1;
            end
            ST_ST1: s[SIG_DMEM_W_EN] = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dibu_ctrl_alu_mem_alu.sv
// 8-bit combinational ALU producing {4'b0, V, C, N, Z} flags.
module dibu_alu
    import dibu_ctrl_alu_mem_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] op,
    output logic [7:0] result,
    output logic [7:0] flags
);

    logic [8:0] sum_ext;
    logic [8:0] diff_ext;
    logic       carry;
    logic       overflow;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (alu_op_t'(op))
            ALU_ADD: begin
                result   = sum_ext[7:0];
                carry    = sum_ext[8];
                overflow = (a[7] == b[7]) && (sum_ext[7] != a[7]);
            end
            ALU_SUB: begin
                // Bit 8 of the widened difference is the borrow, i.e. a < b.
                result   = diff_ext[7:0];
                carry    = diff_ext[8];
                overflow = (a[7] != b[7]) && (diff_ext[7] != a[7]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOT: result = ~a;
            ALU_SHL: begin
                result = {a[6:0], 1'b0};
                carry  = a[7];
            end
            ALU_SHR: begin
                result = {1'b0, a[7:1]};
                carry  = a[0];
            end
            default: result = '0;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (result == 8'h00);
        flags[FLAG_N] = result[7];
        flags[FLAG_C] = carry;
        flags[FLAG_V] = overflow;
    end

endmodule

// File: rtl/dibu_ctrl_alu_mem_sync_ram.sv
// Parameterized RAM: synchronous write, asynchronous read, zero-initialised
// contents that survive reset.
module sync_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[addr] <= d_in;
        end
    end

    // Read-during-write sees the old word until the edge commits the new one.
    assign d_out = mem[addr];

endmodule

// File: rtl/dibu_ctrl_alu_mem.sv
// dibu leaf bundle: microprogrammed control sequencer (Moore FSM), ALU and
// one parameterized RAM instance.
module dibu_ctrl_alu_mem
    import dibu_ctrl_alu_mem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic [4:0]              opcode,
    output logic [SIGNALS_SIZE-1:0] signals,
    output logic                    halted,
    input  logic [7:0]              alu_a,
    input  logic [7:0]              alu_b,
    input  logic [2:0]              alu_op,
    output logic [7:0]              alu_out,
    output logic [7:0]              alu_flags,
    input  logic                    mem_w_en,
    input  logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       mem_d_in,
    output logic [DATA_W-1:0]       mem_d_out
);

    state_t                  state_reg;
    state_t                  state_next;
    logic [SIGNALS_SIZE-1:0] signals_reg;
    logic                    halted_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_F0: state_next = ST_F1;
            ST_F1: state_next = ST_D;
            ST_D: begin
                casez (opcode)
                    5'b00???:       state_next = ST_ALU;
                    OP_LDI:         state_next = ST_LDI;
                    OP_RDF:         state_next = ST_RDF;
                    OP_LD_DIRECT,
                    OP_LD_INDIRECT: state_next = ST_LD0;
                    OP_ST_DIRECT,
                    OP_ST_INDIRECT: state_next = ST_ST0;
                    OP_HALT:        state_next = ST_HALT;
                    default:        state_next = ST_F0;
                endcase
            end
            ST_LD0:  state_next = ST_LD1;
            ST_LD1:  state_next = ST_LD2;
            ST_ST0:  state_next = ST_ST1;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_F0;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_reg.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_F0;
            signals_reg <= state_signals(ST_F0);
            halted_reg  <= 1'b0;
        end else if (run) begin
            state_reg   <= state_next;
            signals_reg <= state_signals(state_next);
            halted_reg  <= (state_next == ST_HALT);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < SIGNALS_SIZE; gi++) begin : g_run_gate
            assign signals[gi] = signals_reg[gi] & run;
        end
    endgenerate

    assign halted = halted_reg;

    dibu_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_out),
        .flags  (alu_flags)
    );

    sync_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .w_en  (mem_w_en),
        .addr  (mem_addr),
        .d_in  (mem_d_in),
        .d_out (mem_d_out)
    );

endmodule

// File: tb/tb_dibu_ctrl_alu_mem.sv
// Directed bench for dibu_ctrl_alu_mem: sequencer walks, ALU vectors, RAM
// write/read, run hold, mid-instruction reset and HALT.
module tb_dibu_ctrl_alu_mem;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic [4:0]        opcode;
    logic [12:0]       signals;
    logic              halted;
    logic [7:0]        alu_a;
    logic [7:0]        alu_b;
    logic [2:0]        alu_op;
    logic [7:0]        alu_out;
    logic [7:0]        alu_flags;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_d_in;
    logic [DATA_W-1:0] mem_d_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dibu_ctrl_alu_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .opcode    (opcode),
        .signals   (signals),
        .halted    (halted),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .alu_flags (alu_flags),
        .mem_w_en  (mem_w_en),
        .mem_addr  (mem_addr),
        .mem_d_in  (mem_d_in),
        .mem_d_out (mem_d_out)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
        $display("check %-14s observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_sig(input string tag, input logic [12:0] expected);
        step();
        check(tag, {19'b0, signals}, {19'b0, expected});
    endtask

    task automatic alu_vec(input string tag, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] r, input logic [7:0] f);
        alu_op = op;
        alu_a  = a;
        alu_b  = b;
        #1;
        check({tag, "_out"}, {24'b0, alu_out}, {24'b0, r});
        check({tag, "_flg"}, {24'b0, alu_flags}, {24'b0, f});
    endtask

    initial begin
        rst = 1'b1; run = 1'b1; opcode = 5'b00000;
        alu_a = '0; alu_b = '0; alu_op = '0;
        mem_w_en = 1'b0; mem_addr = '0; mem_d_in = '0;

        // ALU instruction walk
        step_sig("rst_f0", 13'h006);
        check("rst_halted", {31'b0, halted}, 32'h0);
        rst = 1'b0;
        step_sig("alu_f1", 13'h001);
        step_sig("alu_d", 13'h000);
        step_sig("alu_ex", 13'h1018);
        step_sig("alu_f0", 13'h006);

        // direct load
        opcode = 5'b10000;
        step_sig("ld_f1", 13'h001);
        step_sig("ld_d", 13'h000);
        step_sig("ld0", 13'h080);
        step_sig("ld1", 13'h100);
        step_sig("ld2", 13'h408);
        step_sig("ld_f0", 13'h006);

        // indirect store
        opcode = 5'b10011;
        step_sig("st_f1", 13'h001);
        step_sig("st_d", 13'h000);
        step_sig("st0", 13'h980);
        step_sig("st1", 13'h200);
        step_sig("st_f0", 13'h006);

        // LDI, then an undefined opcode takes the 3-cycle NOP path
        opcode = 5'b01000;
        step_sig("ldi_f1", 13'h001);
        step_sig("ldi_d", 13'h000);
        step_sig("ldi_ex", 13'h048);
        step_sig("ldi_f0", 13'h006);
        opcode = 5'b01010;
        step_sig("nop_f1", 13'h001);
        step_sig("nop_d", 13'h000);
        step_sig("nop_f0", 13'h006);

        // run low in LD1 holds the state and blanks signals
        opcode = 5'b10010;
        step_sig("hold_f1", 13'h001);
        step_sig("hold_d", 13'h000);
        step_sig("hold_ld0", 13'h080);
        step_sig("hold_ld1", 13'h100);
        run = 1'b0;
        #1;
        check("hold_off", {19'b0, signals}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step_sig($sformatf("hold_c%0d", i), 13'h000);
        end
        run = 1'b1;
        #1;
        check("hold_resume", {19'b0, signals}, 32'h100);
        step_sig("hold_ld2", 13'h408);
        step_sig("hold_f0", 13'h006);

        // reset mid-store
        opcode = 5'b10001;
        step_sig("rs_f1", 13'h001);
        step_sig("rs_d", 13'h000);
        step_sig("rs_st0", 13'h980);
        rst = 1'b1;
        step_sig("rs_f0", 13'h006);
        rst = 1'b0;
        step_sig("rs_f1b", 13'h001);

        // HALT is sticky until reset
        opcode = 5'b11111;
        step_sig("hlt_d", 13'h000);
        step_sig("hlt_ex", 13'h000);
        check("hlt_flag", {31'b0, halted}, 32'h1);
        opcode = 5'b00000;
        for (int i = 0; i < 3; i++) begin
            step_sig($sformatf("hlt_stay%0d", i), 13'h000);
            check($sformatf("hlt_flag%0d", i), {31'b0, halted}, 32'h1);
        end
        rst = 1'b1;
        step_sig("hlt_rst", 13'h006);
        check("hlt_clear", {31'b0, halted}, 32'h0);
        rst = 1'b0;

        // ALU vectors
        alu_vec("add_ovf", 3'b000, 8'h7F, 8'h01, 8'h80, 8'h0A);
        alu_vec("add_carry", 3'b000, 8'hFF, 8'h01, 8'h00, 8'h05);
        alu_vec("sub_zero", 3'b001, 8'h05, 8'h05, 8'h00, 8'h01);
        alu_vec("sub_borrow", 3'b001, 8'h00, 8'h01, 8'hFF, 8'h06);
        alu_vec("sub_ovf", 3'b001, 8'h80, 8'h01, 8'h7F, 8'h08);
        alu_vec("and", 3'b010, 8'hF0, 8'h0F, 8'h00, 8'h01);
        alu_vec("or", 3'b011, 8'h80, 8'h01, 8'h81, 8'h02);
        alu_vec("xor", 3'b100, 8'hAA, 8'hFF, 8'h55, 8'h00);
        alu_vec("not", 3'b101, 8'h0F, 8'h33, 8'hF0, 8'h02);
        alu_vec("shl", 3'b110, 8'h81, 8'h00, 8'h02, 8'h04);
        alu_vec("shr", 3'b111, 8'h01, 8'h00, 8'h00, 8'h05);

        // RAM: top and bottom addresses, read-during-write, write enable low
        mem_w_en = 1'b1; mem_addr = 10'h3FF; mem_d_in = 8'hA5;
        #1;
        check("ram_old", {24'b0, mem_d_out}, 32'h00);
        step();
        check("ram_new", {24'b0, mem_d_out}, 32'hA5);
        mem_addr = 10'h000; mem_d_in = 8'h5A;
        step();
        mem_w_en = 1'b0;
        #1;
        check("ram_rd0", {24'b0, mem_d_out}, 32'h5A);
        mem_addr = 10'h3FF;
        #1;
        check("ram_rd3ff", {24'b0, mem_d_out}, 32'hA5);
        mem_d_in = 8'hFF;
        step();
        check("ram_noweA", {24'b0, mem_d_out}, 32'hA5);
        mem_addr = 10'h000;
        step();
        check("ram_noweB", {24'b0, mem_d_out}, 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
